psram_wb_arbiter: RTL
=====================

Name: psram_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares a single PSRAM Wishbone slave port (the quad-SPI PSRAM controller) between requesters, e.g. an instruction-fetch master (M0) and a data master (M1).
- Grants one master at a time using round-robin arbitration.
- Registers the winning request and holds it stable toward the slave until the slave acks. The PSRAM controller cannot abort a transfer mid-flight, so the held request always runs to completion.
- Sits between the core-side bus masters and the PSRAM controller's Wishbone port.

Parameters:
TIMEOUT_CYCLES, 1023, maximum cycles a granted transfer may wait for s_ack_i (used only with PSRAM_ARB_TIMEOUT_EN); must exceed controller init delay plus worst-case transfer time.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m0_adr_i, m1_adr_i  in  32  master address
m0_dat_i, m1_dat_i  in  32  master write data
m0_sel_i, m1_sel_i  in  4  master byte selects
m0_we_i, m1_we_i  in  1  master write enable
m0_cyc_i, m1_cyc_i  in  1  master cycle
m0_stb_i, m1_stb_i  in  1  master strobe
m0_dat_o, m1_dat_o  out  32  read data; both driven directly from s_dat_i
m0_ack_o, m1_ack_o  out  1  transfer acknowledge
m0_err_o, m1_err_o  out  1  timeout error pulse; constant 0 without the feature
s_adr_o  out  32  registered address to slave
s_dat_o  out  32  registered write data
s_sel_o  out  4  registered byte selects
s_we_o  out  1  registered write enable
s_cyc_o, s_stb_o  out  1  registered cycle/strobe; always equal to each other
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave acknowledge
grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- Requests: reqX = mX_cyc_i & mX_stb_i.
- States: IDLE, BUSY0, BUSY1. Registered last_grant bit.
- Reset values: state=IDLE, last_grant=1 (so M0 wins the first tie), all s_* outputs 0, grant_o=00, orphan=0, all ack/err outputs 0.
- IDLE arbitration:
  - Only req0 -> BUSY0. Only req1 -> BUSY1.
  - Both -> grant the master not equal to last_grant.
  - Neither -> stay in IDLE.
- On grant (same clock edge):
  - Latch adr/dat/sel/we of the winner into s_*.
  - Set s_cyc_o = s_stb_o = 1, grant_o one-hot, last_grant = winner, orphan = 0.
  - Latency: request seen in cycle N -> s_stb_o high in cycle N+1.
- BUSYx:
  - s_* outputs held constant; master input changes are ignored.
  - mX_ack_o = s_ack_i & ~orphan. This is combinational, so the ack arrives in the same cycle as s_ack_i.
  - The non-granted master's ack stays 0 and its request waits (it stays asserted by Wishbone rules).
  - On s_ack_i: clear s_cyc_o/s_stb_o and go to IDLE. A new grant is possible in the following cycle at the earliest, which guarantees at least one cycle of s_cyc_o=0 between slave transfers (the controller re-enters its idle state).
- Orphan handling:
  - If the granted master deasserts mX_cyc_i before s_ack_i, set orphan=1.
  - The transfer continues to completion; the ack is swallowed, not delivered.
  - A master re-asserting cyc while orphan=1 is not served until after IDLE.
- Simultaneous cases:
  - s_ack_i in the same cycle as an orphaning cyc drop: orphan is registered too late, so this ack is still delivered; treat it as delivered.
  - Requests arriving in the ack cycle are arbitrated in the next IDLE cycle.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous). Slave-side cleanup is the slave's responsibility.
- Data routing: m0_dat_o = m1_dat_o = s_dat_i at all times; only ack qualifies the data.

Optional Feature:
PSRAM_ARB_TIMEOUT_EN
- Defined:
  - A wait counter, width clog2(TIMEOUT_CYCLES+1), clears on grant and increments each BUSY cycle without s_ack_i.
  - When the counter reaches TIMEOUT_CYCLES with no ack:
    - Pulse mX_err_o for one cycle to the granted master (suppressed if orphan).
    - Clear s_cyc_o/s_stb_o and go to IDLE.
    - mX_ack_o stays 0.
  - If s_ack_i and the timeout occur in the same cycle, the ack wins and err is not asserted.
- Undefined: no counter, m0_err_o = m1_err_o = 0, BUSY waits indefinitely for s_ack_i.

Test Plan:
- M0 read only, adr=0x0000_0010, slave acks 5 cycles after s_stb_o with s_dat_i=0xDEADBEEF -> s_stb_o rises 1 cycle after the request; m0_ack_o pulses in the same cycle as s_ack_i; m0_dat_o=0xDEADBEEF; grant_o=01→00.
- M0 and M1 request in the same cycle after reset -> M0 granted first. M1 granted in the cycle after IDLE following M0's ack, with s_cyc_o low for ≥1 cycle between the two transfers.
- M0 and M1 both request continuously for 4 transfers -> grant order M0, M1, M0, M1.
- M1 write, sel=0011, dat=0x1234_5678; M1 changes adr/dat while in BUSY1 -> s_adr_o/s_dat_o/s_sel_o keep the originally latched values until s_ack_i.
- M0 drops cyc 2 cycles after grant; slave acks later -> m0_ack_o stays 0, s_cyc_o stays high until s_ack_i, then state returns to IDLE.
- With PSRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks -> m0_err_o pulses once, 8 cycles after grant; s_cyc_o drops and state returns to IDLE. Without the macro: no err, s_cyc_o stays high.

Source files
------------

// File: rtl/psram_wb_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the PSRAM slave.
// Modports: slave = arbiter side, master = requester/PSRAM side.
interface psram_wb_arbiter_if;
   logic [31:0] m0_adr_i, m1_adr_i;
   logic [31:0] m0_dat_i, m1_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m1_we_i;
   logic        m0_cyc_i, m1_cyc_i;
   logic        m0_stb_i, m1_stb_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m1_ack_o;
   logic        m0_err_o, m1_err_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o;
   logic        s_cyc_o, s_stb_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic [1:0]  grant_o;

   modport slave (
      input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
      input  m0_sel_i, m1_sel_i, m0_we_i, m1_we_i,
      input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
      output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
      output m0_err_o, m1_err_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o,
      output s_cyc_o, s_stb_o,
      input  s_dat_i, s_ack_i,
      output grant_o
   );

   modport master (
      output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
      output m0_sel_i, m1_sel_i, m0_we_i, m1_we_i,
      output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
      input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
      input  m0_err_o, m1_err_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o,
      input  s_cyc_o, s_stb_o,
      output s_dat_i, s_ack_i,
      input  grant_o
   );
endinterface

// File: rtl/psram_wb_arbiter.sv
// Round-robin arbiter sharing one PSRAM Wishbone slave between M0 and M1.
// Ports: clk_i, rst_i (async, active-high), bus (psram_wb_arbiter_if.slave).
// Optional watchdog enabled by defining PSRAM_ARB_TIMEOUT_EN.
module psram_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input logic clk_i,
   input logic rst_i,
   psram_wb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t      state;
   logic        last_grant;
   logic        orphan;
   logic [31:0] adr_q, dat_q;
   logic [3:0]  sel_q;
   logic        we_q, cyc_q;
   logic [1:0]  grant_q;

   logic req0, req1, win0, own_cyc, timeout;

   assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
   assign req1 = bus.m1_cyc_i & bus.m1_stb_i;
   // On a tie the master that did not win last time gets the slave.
   assign win0 = req0 & (~req1 | last_grant);
   assign own_cyc = grant_q[1] ? bus.m1_cyc_i : bus.m0_cyc_i;

`ifdef PSRAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   logic          busy;

   assign busy = (state != IDLE);

   // Zero in IDLE, so every grant starts from zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         wait_cnt <= '0;
      else if (!busy)
         wait_cnt <= '0;
      else if (!bus.s_ack_i)
         wait_cnt <= wait_cnt + CW'(1);
   end

   // A late ack still wins over the watchdog.
   assign timeout = busy & ~bus.s_ack_i
                  & (wait_cnt == CW'(TIMEOUT_CYCLES));
`else
   // No watchdog: a granted transfer waits for the ack forever.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         orphan     <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         grant_q    <= 2'b00;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  adr_q      <= win0 ? bus.m0_adr_i : bus.m1_adr_i;
                  dat_q      <= win0 ? bus.m0_dat_i : bus.m1_dat_i;
                  sel_q      <= win0 ? bus.m0_sel_i : bus.m1_sel_i;
                  we_q       <= win0 ? bus.m0_we_i  : bus.m1_we_i;
                  cyc_q      <= 1'b1;
                  grant_q    <= win0 ? 2'b01 : 2'b10;
                  last_grant <= ~win0;
                  orphan     <= 1'b0;
                  state      <= win0 ? BUSY0 : BUSY1;
               end
            end
            BUSY0, BUSY1: begin
               if (bus.s_ack_i | timeout) begin
                  cyc_q   <= 1'b0;
                  grant_q <= 2'b00;
                  state   <= IDLE;
               end else if (!own_cyc) begin
                  // Controller cannot abort; finish and swallow the ack.
                  orphan <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_adr_o  = adr_q;
   assign bus.s_dat_o  = dat_q;
   assign bus.s_sel_o  = sel_q;
   assign bus.s_we_o   = we_q;
   assign bus.s_cyc_o  = cyc_q;
   assign bus.s_stb_o  = cyc_q;
   assign bus.grant_o  = grant_q;

   assign bus.m0_dat_o = bus.s_dat_i;
   assign bus.m1_dat_o = bus.s_dat_i;

   assign bus.m0_ack_o = grant_q[0] & bus.s_ack_i & ~orphan;
   assign bus.m1_ack_o = grant_q[1] & bus.s_ack_i & ~orphan;
   assign bus.m0_err_o = grant_q[0] & timeout & ~orphan;
   assign bus.m1_err_o = grant_q[1] & timeout & ~orphan;

endmodule
